sw_debounce_sync: RTL and testbench

Conditions raw board switch/push-button levels before they reach the Nios II input PIO. Each bit gets a 2-flop synchronizer and a debounce filter; a level is accepted only after it has stayed stable for a programmable number of clocks. The block drives the PIO `in_port` with clean levels. One-cycle rise/fall/changed strobes are available for edge-capture or IRQ logic.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_sync_if.sv | 28 ++
 rtl/sw_debounce_bit.sv | 101 ++++++++++
 rtl/sw_debounce_sync.sv | 49 ++++
 tb/tb_sw_debounce_sync.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared FSM state type and counter-width helper for the switch debouncer
package sw_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  // Counter must be able to represent DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_sync_if.sv
// rtl/sw_debounce_sync_if.sv - switch level bundle between the raw pins and the PIO/IRQ side
interface sw_debounce_sync_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output rise,
    output fall,
    output changed
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one-bit synchronizer, stability counter and accept/abort FSM
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  // Accept happens on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          mismatch;
  db_state_e     state;
  db_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign mismatch = (sync2 != sw_clean);

  // Two-flop synchronizer for the asynchronous switch pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: count while mismatched, abort on return, accept at threshold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      STABLE: begin
        if (mismatch) begin
          state_nxt = PENDING;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      PENDING: begin
        if (!mismatch) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          accept    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clean level and edge strobes update together on the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_clean <= RESET_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      if (accept) begin
        sw_clean <= sync2;
      end
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end

endmodule

// File: rtl/sw_debounce_sync.sv
// rtl/sw_debounce_sync.sv - WIDTH-bit switch debouncer feeding the PIO in_port with edge strobes
module sw_debounce_sync
  import sw_debounce_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  sw_debounce_sync_if.slave sw
);

  logic [WIDTH-1:0] clean_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] accept_vec;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[i])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw   (sw.sw_raw[i]),
      .sw_clean (clean_vec[i]),
      .rise     (rise_vec[i]),
      .fall     (fall_vec[i]),
      .accept   (accept_vec[i])
    );
  end

  // One changed pulse per accept edge, aligned with the per-bit strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |accept_vec;
    end
  end

  assign sw.sw_clean = clean_vec;
  assign sw.rise     = rise_vec;
  assign sw.fall     = fall_vec;
  assign sw.changed  = changed_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb/tb_sw_debounce_sync.sv - scoreboard bench for sw_debounce_sync with directed vectors
module tb_sw_debounce_sync;

  typedef struct {
    int         cyc;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [3:0] exp_clean = 4'b0000;

  sw_debounce_sync_if #(.WIDTH(4)) sw ();

  sw_debounce_sync #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .RESET_VAL       (4'b0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (sw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int c, input logic [3:0] cl, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.clean = cl; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation on every changed pulse, otherwise checks quiet strobes and held level.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) exp_clean = 4'b0000;
    if (sw.changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_changed", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_clean", int'(sw.sw_clean), int'(e.clean));
        chk("event_rise", int'(sw.rise), int'(e.rise));
        chk("event_fall", int'(sw.fall), int'(e.fall));
        exp_clean = e.clean;
      end
    end else begin
      chk("quiet_strobes", int'({sw.rise, sw.fall}), 0);
    end
    chk("clean_level", int'(sw.sw_clean), int'(exp_clean));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    sw.sw_raw = 4'b1010;
    tick(3);
    chk("reset_clean", int'(sw.sw_clean), 0);
    chk("reset_strobes", int'({sw.rise, sw.fall, sw.changed}), 0);

    // 1. reset exit with raw differing from RESET_VAL
    reset_n = 1'b1;
    expect_evt(cyc + 10, 4'b1010, 4'b1010, 4'b0000);
    tick(14);
    sw.sw_raw = 4'b0000;
    expect_evt(cyc + 10, 4'b0000, 4'b0000, 4'b1010);
    tick(14);

    // 2. glitch rejection: 5- and 7-clock pulses
    sw.sw_raw = 4'b0001;
    tick(5);
    sw.sw_raw = 4'b0000;
    tick(12);
    sw.sw_raw = 4'b0001;
    tick(7);
    sw.sw_raw = 4'b0000;
    tick(12);

    // 3. accept at threshold, rise then fall
    sw.sw_raw = 4'b0100;
    expect_evt(cyc + 10, 4'b0100, 4'b0100, 4'b0000);
    tick(14);
    sw.sw_raw = 4'b0000;
    expect_evt(cyc + 10, 4'b0000, 4'b0000, 4'b0100);
    tick(14);

    // 4. all bits on the same edge
    sw.sw_raw = 4'b1111;
    expect_evt(cyc + 10, 4'b1111, 4'b1111, 4'b0000);
    tick(14);
    sw.sw_raw = 4'b0000;
    expect_evt(cyc + 10, 4'b0000, 4'b0000, 4'b1111);
    tick(14);

    // 5. bounce train on bit 1, then hold high
    for (int i = 0; i < 14; i++) begin
      sw.sw_raw[1] = (i % 2 == 0);
      tick(3);
    end
    sw.sw_raw[1] = 1'b1;
    expect_evt(cyc + 10, 4'b0010, 4'b0010, 4'b0000);
    tick(14);
    sw.sw_raw = 4'b0000;
    expect_evt(cyc + 10, 4'b0000, 4'b0000, 4'b0010);
    tick(14);

    // 6. reset while bit 3 is pending
    sw.sw_raw = 4'b1000;
    tick(7);
    reset_n = 1'b0;
    tick(3);
    chk("midreset_clean", int'(sw.sw_clean), 0);
    chk("midreset_strobes", int'({sw.rise, sw.fall, sw.changed}), 0);
    reset_n = 1'b1;
    expect_evt(cyc + 10, 4'b1000, 4'b1000, 4'b0000);
    tick(14);

    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
